// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the Wishbone-to-async-SRAM controller.
package sram_ctrl_pkg;

   localparam int WAIT_W = 4;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      WSETUP,
      WPULSE,
      WHOLD
   } state_e;

   // Parameter sanity: whole byte lanes, wait counts fit the wait counter.
   function automatic bit cfg_ok(input int dw, input int rd_wait, input int wr_wait);
      return (dw > 0) && (dw % 8 == 0) &&
             (rd_wait >= 0) && (rd_wait < 2**WAIT_W) &&
             (wr_wait >= 0) && (wr_wait < 2**WAIT_W);
   endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Wishbone B4 pipelined slave driving an asynchronous SRAM with fully
// registered strobes, programmable wait states and abort on CYC_I negation.
module sram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int DW      = 16,
   parameter int AW      = 19,
   parameter int RD_WAIT = 1,
   parameter int WR_WAIT = 1
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              cyc_i,
   input  logic              stb_i,
   input  logic              we_i,
   input  logic [DW/8-1:0]   sel_i,
   input  logic [AW-1:0]     adr_i,
   input  logic [DW-1:0]     dat_i,
   output logic              ack_o,
   output logic [DW-1:0]     dat_o,
   output logic              stall_o,
   output logic              _sram_ce,
   output logic              _sram_we,
   output logic              _sram_oe,
   output logic [DW/8-1:0]   _sram_bs,
   output logic [AW-1:0]     sram_a,
   output logic [DW-1:0]     sram_d_out,
   output logic              sram_d_oe,
   input  logic [DW-1:0]     sram_d_in
);

   localparam int NB = DW / 8;

   if (!cfg_ok(DW, RD_WAIT, WR_WAIT)) begin : g_cfg_err
      $error("sram_ctrl: DW must be a multiple of 8 and wait states 0..15");
   end

   state_e            state_q, state_n;
   logic [WAIT_W-1:0] cnt_q, cnt_n;
   logic              live_q, live_n;
   logic              done_q, done_n;
   logic              accept;
   logic              cap_rd;

   // live tracks whether the master kept CYC_I up for the whole transfer.
   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      live_n  = live_q;
      done_n  = 1'b0;
      accept  = 1'b0;
      cap_rd  = 1'b0;
      if (state_q != IDLE && !cyc_i) live_n = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cyc_i && stb_i) begin
               accept = 1'b1;
               live_n = 1'b1;
               if (we_i) begin
                  state_n = WSETUP;
               end else begin
                  state_n = RD;
                  cnt_n   = WAIT_W'(RD_WAIT);
               end
            end
         end
         RD: begin
            if (cnt_q == '0) begin
               state_n = IDLE;
               cap_rd  = 1'b1;
               done_n  = live_n;
            end else begin
               cnt_n = cnt_q - WAIT_W'(1);
            end
         end
         WSETUP: begin
            state_n = WPULSE;
            cnt_n   = WAIT_W'(WR_WAIT);
         end
         WPULSE: begin
            if (cnt_q == '0) state_n = WHOLD;
            else             cnt_n   = cnt_q - WAIT_W'(1);
         end
         WHOLD: begin
            state_n = IDLE;
            done_n  = live_n;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         live_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         cnt_q   <= cnt_n;
         live_q  <= live_n;
         done_q  <= done_n;
      end
   end

   // Strobes are decoded from the next state so every pad-facing signal is a flop.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         _sram_ce   <= 1'b1;
         _sram_oe   <= 1'b1;
         _sram_we   <= 1'b1;
         sram_d_oe  <= 1'b0;
         stall_o    <= 1'b0;
         _sram_bs   <= {NB{1'b1}};
         sram_a     <= '0;
         sram_d_out <= '0;
         dat_o      <= '0;
      end else begin
         _sram_ce  <= (state_n == IDLE);
         _sram_oe  <= (state_n != RD);
         _sram_we  <= (state_n != WPULSE);
         sram_d_oe <= (state_n == WSETUP) || (state_n == WPULSE) || (state_n == WHOLD);
         stall_o   <= (state_n != IDLE);
         if (accept) begin
            _sram_bs   <= ~sel_i;
            sram_a     <= adr_i;
            sram_d_out <= dat_i;
         end
         if (cap_rd) dat_o <= sram_d_in;
      end
   end

   assign ack_o = done_q & cyc_i;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: a cycle-offset model checked every cycle on
// two instances (RD_WAIT=1 and RD_WAIT=0), plus literal spot checks.
module tb_sram_ctrl;

   localparam int WW = 1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cyc, stb, we;
   logic [1:0]  sel;
   logic [18:0] adr;
   logic [15:0] dat, din;

   logic        ack   [2];
   logic        stall [2];
   logic        ce_n  [2];
   logic        we_n  [2];
   logic        oe_n  [2];
   logic        d_oe  [2];
   logic [1:0]  bs    [2];
   logic [18:0] sa    [2];
   logic [15:0] dout  [2];
   logic [15:0] rdat  [2];

   int total = 0;
   int bad   = 0;
   bit run   = 0;

   always #5 clk = ~clk;

   sram_ctrl #(.DW(16), .AW(19), .RD_WAIT(1), .WR_WAIT(WW)) dut (
      .clk_i(clk), .reset_i(rst_n), .cyc_i(cyc), .stb_i(stb), .we_i(we),
      .sel_i(sel), .adr_i(adr), .dat_i(dat), .ack_o(ack[0]), .dat_o(rdat[0]),
      .stall_o(stall[0]), ._sram_ce(ce_n[0]), ._sram_we(we_n[0]), ._sram_oe(oe_n[0]),
      ._sram_bs(bs[0]), .sram_a(sa[0]), .sram_d_out(dout[0]), .sram_d_oe(d_oe[0]),
      .sram_d_in(din));

   sram_ctrl #(.DW(16), .AW(19), .RD_WAIT(0), .WR_WAIT(WW)) dut0 (
      .clk_i(clk), .reset_i(rst_n), .cyc_i(cyc), .stb_i(stb), .we_i(we),
      .sel_i(sel), .adr_i(adr), .dat_i(dat), .ack_o(ack[1]), .dat_o(rdat[1]),
      .stall_o(stall[1]), ._sram_ce(ce_n[1]), ._sram_we(we_n[1]), ._sram_oe(oe_n[1]),
      ._sram_bs(bs[1]), .sram_a(sa[1]), .sram_d_out(dout[1]), .sram_d_oe(d_oe[1]),
      .sram_d_in(din));

   function automatic int rw(input int i);
      return (i == 0) ? 1 : 0;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Model: a transfer occupies cycles 1..len after its accept cycle 0,
   // len = RD_WAIT+1 for reads and WR_WAIT+3 for writes; ack follows in the next cycle.
   bit          m_busy [2];
   int          m_t    [2];
   bit          m_we   [2];
   bit          m_live [2];
   bit          m_done [2];
   logic [15:0] m_rdat [2];
   logic [15:0] m_dout [2];
   logic [18:0] m_a    [2];
   logic [1:0]  m_bs   [2];

   always @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            m_busy[i] <= 1'b0; m_t[i] <= 0; m_we[i] <= 1'b0; m_live[i] <= 1'b0;
            m_done[i] <= 1'b0; m_rdat[i] <= '0; m_dout[i] <= '0; m_a[i] <= '0;
            m_bs[i] <= 2'b11;
         end else begin
            m_done[i] <= 1'b0;
            if (m_busy[i]) begin
               if (!m_we[i] && m_t[i] == rw(i) + 1) m_rdat[i] <= din;
               if (m_t[i] == (m_we[i] ? WW + 3 : rw(i) + 1)) begin
                  m_busy[i] <= 1'b0;
                  m_done[i] <= m_live[i] && cyc;
               end else begin
                  m_t[i] <= m_t[i] + 1;
               end
               if (!cyc) m_live[i] <= 1'b0;
            end else if (cyc && stb) begin
               m_busy[i] <= 1'b1; m_t[i] <= 1; m_we[i] <= we; m_live[i] <= 1'b1;
               m_a[i] <= adr; m_dout[i] <= dat; m_bs[i] <= ~sel;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (run) begin
         for (int i = 0; i < 2; i++) begin
            logic [5:0] e_ctl, a_ctl;
            e_ctl = {m_busy[i], !m_busy[i], !(m_busy[i] && !m_we[i]),
                     !(m_busy[i] && m_we[i] && m_t[i] >= 2 && m_t[i] <= WW + 2),
                     m_busy[i] && m_we[i], m_done[i] && cyc};
            a_ctl = {stall[i], ce_n[i], oe_n[i], we_n[i], d_oe[i], ack[i]};
            chk($sformatf("ctl[%0d]", i), 32'(a_ctl), 32'(e_ctl));
            chk($sformatf("dat_o[%0d]", i), 32'(rdat[i]), 32'(m_rdat[i]));
            chk($sformatf("sram_a[%0d]", i), 32'(sa[i]), 32'(m_a[i]));
            chk($sformatf("d_out[%0d]", i), 32'(dout[i]), 32'(m_dout[i]));
            chk($sformatf("bs[%0d]", i), 32'(bs[i]), 32'(m_bs[i]));
            chk($sformatf("contention[%0d]", i), 32'(d_oe[i] && !oe_n[i]), 32'(0));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic w, input logic [18:0] a, input logic [15:0] d,
                      input logic [1:0] s);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
   endtask

   initial begin
      rst_n = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0;
      dat = '0; din = '0;
      #1 rst_n = 1'b0;
      #2;
      chk("rst ce", 32'(ce_n[0]), 32'd1);
      chk("rst d_oe", 32'(d_oe[0]), 32'd0);
      chk("rst stall", 32'(stall[0]), 32'd0);
      chk("rst bs", 32'(bs[0]), 32'h3);
      run = 1'b1;
      step(); step();
      rst_n = 1'b1;
      step();

      // stb without cyc is ignored
      stb = 1'b1;
      step(); step();
      chk("stb only stall", 32'(stall[0]), 32'd0);
      stb = 1'b0;
      step();

      // 1: read
      req(1'b0, 19'h00003, 16'h0, 2'b11); din = 16'hF00D;
      step(); stb = 1'b0;
      chk("t1 a", 32'(sa[0]), 32'h3);
      chk("t1 oe c1", 32'(oe_n[0]), 32'd0);
      chk("t1 stall c1", 32'(stall[0]), 32'd1);
      step();
      chk("t1 oe c2", 32'(oe_n[0]), 32'd0);
      step();
      chk("t1 ack c3", 32'(ack[0]), 32'd1);
      chk("t1 dat c3", 32'(rdat[0]), 32'hF00D);
      step(); cyc = 1'b0;
      step();

      // 2: write
      req(1'b1, 19'h00001, 16'h1234, 2'b10);
      step(); stb = 1'b0;
      chk("t2 bs", 32'(bs[0]), 32'h1);
      chk("t2 dout", 32'(dout[0]), 32'h1234);
      chk("t2 we c1", 32'(we_n[0]), 32'd1);
      step();
      chk("t2 we c2", 32'(we_n[0]), 32'd0);
      step(); step();
      chk("t2 we c4", 32'(we_n[0]), 32'd1);
      chk("t2 doe c4", 32'(d_oe[0]), 32'd1);
      step();
      chk("t2 ack c5", 32'(ack[0]), 32'd1);
      chk("t2 doe c5", 32'(d_oe[0]), 32'd0);
      step(); cyc = 1'b0;
      step();

      // 3: read then write, stb held
      req(1'b0, 19'h00005, 16'h0, 2'b11); din = 16'hBEEF;
      step();
      req(1'b1, 19'h00006, 16'h5555, 2'b11);
      step(); step();
      chk("t3 rd ack", 32'(ack[0]), 32'd1);
      chk("t3 rd dat", 32'(rdat[0]), 32'hBEEF);
      step(); stb = 1'b0;
      chk("t3 wr doe", 32'(d_oe[0]), 32'd1);
      step(); step(); step();
      chk("t3 no early ack", 32'(ack[0]), 32'd0);
      step();
      chk("t3 wr ack", 32'(ack[0]), 32'd1);
      step(); cyc = 1'b0;
      step();

      // 4: cyc dropped in read cycle 1
      req(1'b0, 19'h00007, 16'h0, 2'b11); din = 16'h1111;
      step(); cyc = 1'b0; stb = 1'b0;
      step();
      chk("t4 oe c2", 32'(oe_n[0]), 32'd0);
      step();
      chk("t4 ack c3", 32'(ack[0]), 32'd0);
      chk("t4 stall c3", 32'(stall[0]), 32'd0);
      step();

      // 5: reset in the middle of the write pulse
      req(1'b1, 19'h00009, 16'hABCD, 2'b11);
      step(); stb = 1'b0;
      step();
      chk("t5 we c2", 32'(we_n[0]), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("t5 rst we", 32'(we_n[0]), 32'd1);
      chk("t5 rst ce", 32'(ce_n[0]), 32'd1);
      chk("t5 rst doe", 32'(d_oe[0]), 32'd0);
      chk("t5 rst stall", 32'(stall[0]), 32'd0);
      cyc = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      req(1'b0, 19'h7FFFF, 16'h0, 2'b11); din = 16'h1357;
      step(); stb = 1'b0;
      chk("t5 a max", 32'(sa[0]), 32'h7FFFF);
      step(); step();
      chk("t5 ack", 32'(ack[0]), 32'd1);
      chk("t5 dat", 32'(rdat[0]), 32'h1357);
      step(); cyc = 1'b0;
      step();

      // 6: zero read wait states
      req(1'b0, 19'h12345, 16'h0, 2'b01); din = 16'hA5A5;
      step(); stb = 1'b0;
      chk("t6 oe c1", 32'(oe_n[1]), 32'd0);
      chk("t6 bs", 32'(bs[1]), 32'h2);
      step();
      chk("t6 ack c2", 32'(ack[1]), 32'd1);
      chk("t6 dat c2", 32'(rdat[1]), 32'hA5A5);
      chk("t6 oe c2", 32'(oe_n[1]), 32'd1);
      step(); step(); cyc = 1'b0;
      step();

      // 7: write with no byte lanes still completes
      req(1'b1, 19'h00002, 16'hFFFF, 2'b00);
      step(); stb = 1'b0;
      chk("t7 bs", 32'(bs[0]), 32'h3);
      repeat (4) step();
      chk("t7 ack", 32'(ack[0]), 32'd1);
      step(); cyc = 1'b0;
      step(); step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Parametrised second-generation Wishbone B4 pipelined slave in front of an asynchronous static RAM.
- Generalised data width (byte lanes), address width, and programmable read/write wait states.
- All SRAM strobes are fully registered; there is no clock-phase gating.
- Real STALL_O back-pressure, a driven chip-enable, an explicit data-bus output enable, and abort handling on CYC_I negation.
- Sits between the CPU/Wishbone interconnect and the top-level inout pad binding; pad binding remains the top level's job.

Parameters:
- DW, 16: data width in bits; must be a multiple of 8. Byte lanes NB = DW/8.
- AW, 19: word address width in bits.
- RD_WAIT, 1: extra read access cycles, 0..15.
- WR_WAIT, 1: extra write-pulse cycles, 0..15.

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  asynchronous, active-low reset
- cyc_i  in  1  Wishbone cycle
- stb_i  in  1  Wishbone strobe
- we_i  in  1  write enable
- sel_i  in  NB  byte selects
- adr_i  in  AW  word address
- dat_i  in  DW  write data
- ack_o  out  1  transfer acknowledge
- dat_o  out  DW  read data (registered)
- stall_o  out  1  slave busy
- _sram_ce  out  1  chip enable, active low
- _sram_we  out  1  write strobe, active low
- _sram_oe  out  1  output enable, active low
- _sram_bs  out  NB  byte-lane enables, active low
- sram_a  out  AW  SRAM address
- sram_d_out  out  DW  data to pads
- sram_d_oe  out  1  pad driver enable, active high
- sram_d_in  in  DW  data from pads

Behaviour:
- Reset (asynchronous, immediate, including mid-operation):
  - State IDLE.
  - _sram_ce = _sram_we = _sram_oe = 1, _sram_bs all 1.
  - sram_d_oe = 0, ack_o = 0, stall_o = 0.
  - dat_o, sram_a, sram_d_out = 0.
  - Wait counter = 0.
- FSM states: IDLE, RD, WSETUP, WPULSE, WHOLD. stall_o = 1 in every state except IDLE.
- Acceptance: in IDLE, cyc_i & stb_i at a rising edge latches adr, dat, sel, we into registers that drive sram_a, sram_d_out and _sram_bs (= ~sel). Call this cycle 0.
- Read path:
  - IDLE -> RD for cycles 1..RD_WAIT+1, with _sram_ce = 0 and _sram_oe = 0.
  - dat_o <= sram_d_in at the end of cycle RD_WAIT+1.
  - Return to IDLE; ack_o = 1 in cycle RD_WAIT+2.
- Write path:
  - WSETUP in cycle 1: ce low, sram_d_oe = 1, we high.
  - WPULSE in cycles 2..WR_WAIT+2: _sram_we = 0.
  - WHOLD in cycle WR_WAIT+3: we high, data still driven.
  - Return to IDLE; ack_o = 1 in cycle WR_WAIT+4, with sram_d_oe = 0.
- ack_o:
  - Registered done flag ANDed with the live cyc_i.
  - Exactly one cycle per accepted request, always in an IDLE cycle.
- Back-to-back: a new request is accepted in the same IDLE cycle that carries ack_o. Pipelined throughput is therefore one transfer per RD_WAIT+2 (read) or WR_WAIT+4 (write) cycles.
- Bus contention: sram_d_oe and ~_sram_oe are never both 1 in any cycle. Read-after-write and write-after-read are each separated by at least one IDLE cycle with both deasserted.
- cyc_i negated mid-transfer:
  - The SRAM cycle still completes; a write pulse is never truncated.
  - ack_o is suppressed.
  - The FSM returns to IDLE normally.
- stb_i without cyc_i: ignored.
- sel_i = 0: a full cycle runs with all _sram_bs high, and ack is returned normally.
- dat_o holds its last read value across writes and idle cycles; it is valid only with ack_o on a read.
- Wait counter:
  - Width 4 bits.
  - Loaded with RD_WAIT or WR_WAIT on entry to RD or WPULSE.
  - Decrements to 0; the state exits when the counter is 0.
- _sram_ce is high in IDLE.

Decomposition:
- Package sram_ctrl_pkg holds:
  - the state enum,
  - the wait-counter width constant (4),
  - elaboration checks: DW % 8 == 0 and RD_WAIT/WR_WAIT <= 15.
- No sub-module; the FSM, counter and output registers are one module (about 200 lines).

Test Plan:
All scenarios use DW=16, AW=19, RD_WAIT=1, WR_WAIT=1 unless noted.
1. Read: adr 0x00003, sel 11, sram_d_in = F00D.
   -> sram_a = 3; _oe and _ce low in cycles 1-2; stall 1 in cycles 1-2; ack_o in cycle 3 with dat_o = F00D; sram_d_oe always 0.
2. Write: adr 0x00001, dat 1234, sel 10.
   -> _sram_bs = 01; sram_d_out = 1234 and d_oe = 1 in cycles 1-4; _we low only in cycles 2-3; ack_o in cycle 5.
3. Read then write with stb held (pipelined).
   -> The second request is accepted in the read's ack cycle; no cycle has d_oe = 1 together with _oe = 0; the write ack arrives 5 cycles after the read ack.
4. cyc_i dropped in read cycle 1.
   -> _oe stays low through cycle 2; ack_o = 0 throughout; stall_o = 0 in cycle 3.
5. reset_i asserted in write cycle 2 (_we low).
   -> _we, _ce = 1, d_oe = 0, ack = 0, stall = 0 immediately (before the next edge); after release, a normal read completes.
6. RD_WAIT=0 instance, read with sram_d_in = A5A5.
   -> _oe low in cycle 1 only; ack_o in cycle 2 with dat_o = A5A5.
